countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter/timer that mirrors the team's up-counters: counts a programmed value toward 0 and flags terminal count.
- Supports one-shot and auto-reload modes, plus pause/resume.
- Also provides a free-running 99→0 wrapping down-count for periodic ticks.
- Sits next to the up-counters as the timeout/period source for control FSMs.

Parameters:
- WIDTH, 7, counter width in bits (0~127, no overflow).
- MAX, 100, upper limit for loaded values; free-running count period.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_load  input  1  load i_load_val as count and reload value.
- i_load_val  input  WIDTH  value to load; clamped to MAX.
- i_start  input  1  start or resume counting.
- i_stop  input  1  pause counting.
- i_reload_mode  input  1  0 = one-shot, 1 = auto-reload; sampled when cnt reaches 0.
- o_cnt  output  WIDTH  current count.
- o_busy  output  1  high in RUN.
- o_done  output  1  terminal-count strobe, one cycle.
- o_cnt_always  output  WIDTH  free-running down count, MAX-1 → 0 → MAX-1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset (sampled at posedge clk): state IDLE, cnt=0, reload_val=0, o_busy=0, o_done=0, o_cnt_always=MAX-1. Mid-operation reset overrides all inputs and aborts any run.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per edge: reset > i_load > i_stop > i_start.
- i_load, any state:
  - cnt and reload_val get min(i_load_val, MAX).
  - Next state IDLE; no decrement on that edge.
- i_start:
  - From IDLE or PAUSE with cnt!=0: go to RUN. cnt is unchanged on the start edge; the first decrement is on the next edge.
  - From IDLE with cnt==0: go to DONE, no o_done.
  - From DONE with reload_val!=0: cnt=reload_val, go to RUN.
  - From DONE with reload_val==0: stay in DONE.
  - In RUN: ignored.
- RUN:
  - If cnt!=0: cnt decrements by 1 each edge.
  - If cnt==0 and i_reload_mode=1: cnt=reload_val and stay in RUN. If reload_val==0, go to DONE.
  - If cnt==0 and i_reload_mode=0: go to DONE, cnt holds 0.
- i_stop in RUN: go to PAUSE, cnt holds. In any other state: ignored.
- o_done = (state==RUN && cnt==0), decoded from registers.
  - High for exactly one cycle per terminal count.
  - Auto-reload period is reload_val+1 cycles.
  - Never asserted in IDLE, PAUSE or DONE.
- o_busy = (state==RUN).
- o_cnt = cnt.
- o_cnt_always: decrements every cycle; wraps 0 → MAX-1; unaffected by load/start/stop.
- Arithmetic: unsigned WIDTH-bit; no decrement below 0; MAX must be ≤ 2^WIDTH-1.

Decomposition:
- Shared package: state enum (IDLE, RUN, PAUSE, DONE) and the default MAX/WIDTH constants.
- Sub-module wrap_down_counter (params WIDTH, MAX) produces o_cnt_always. It is reusable as a generic periodic down-tick.

Test Plan:
- Reset → o_cnt=0, o_busy=0, o_done=0, o_cnt_always=99; after 100 cycles o_cnt_always is 99 again, having passed through 0 once.
- Load 5, start, one-shot:
  - o_busy rises the cycle after start; o_cnt runs 5,4,3,2,1,0.
  - o_done is high only while o_cnt=0.
  - Next cycle: DONE, o_cnt=0, o_busy=0.
- Load 3, auto-reload, start: o_cnt repeats 3,2,1,0,3,2,1,0…; o_done pulses every 4 cycles.
- Load 10, start; stop at o_cnt=6:
  - o_cnt holds 6 for 5 cycles with o_busy=0, o_done=0.
  - Start resumes 6,5,… and o_done fires at 0.
- Load 120 → o_cnt=100 (clamped). Load 0 then start → DONE with no o_done. Load and stop asserted together in RUN → load wins, state IDLE.
- Reset asserted mid-run at o_cnt=7 → next cycle o_cnt=0, IDLE, o_cnt_always=99; start with cnt 0 → DONE, no o_done.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: default geometry and FSM state codes.
package countdown_timer_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_MAX   = 100;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/countdown_timer_wrap_down_counter.sv
// Free-running down counter cycling MAX-1 .. 0; usable as a generic periodic tick source.
module wrap_down_counter
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? TOP : cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= TOP;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, pause/resume and a terminal-count strobe.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_reload_mode,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_cnt_always
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  // Priority: load > stop > start; load always parks the FSM in IDLE without decrementing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (i_load) begin
      cnt_d    = clamp_max(i_load_val);
      reload_d = clamp_max(i_load_val);
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (i_start) begin
            state_d = (cnt_q != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            state_d = ST_PAUSE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else if (i_reload_mode && (reload_q != '0)) begin
            cnt_d = reload_q;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_start && (reload_q != '0)) begin
            cnt_d   = reload_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_busy = (state_q == ST_RUN);
  assign o_done = (state_q == ST_RUN) && (cnt_q == '0);

  wrap_down_counter #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_wrap (
    .clk   (clk),
    .reset (reset),
    .o_cnt (o_cnt_always)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: per-cycle stimulus and expected outputs queued together.
module tb_countdown_timer;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_load;
  logic [W-1:0] i_load_val;
  logic         i_start;
  logic         i_stop;
  logic         i_reload_mode;
  logic [W-1:0] o_cnt;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_cnt_always;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .MAX(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_load        (i_load),
    .i_load_val    (i_load_val),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_reload_mode (i_reload_mode),
    .o_cnt         (o_cnt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_cnt_always  (o_cnt_always)
  );

  typedef struct {
    logic         rst;
    logic         load;
    logic [W-1:0] val;
    logic         start;
    logic         stop;
    logic         mode;
  } stim_t;

  typedef struct {
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic sched(input logic rst, input logic load, input logic [W-1:0] val,
                       input logic start, input logic stop, input logic mode,
                       input logic [W-1:0] c, input logic b, input logic d);
    stim_t s;
    exp_t  e;
    s.rst = rst; s.load = load; s.val = val; s.start = start; s.stop = stop; s.mode = mode;
    e.cnt = c; e.busy = b; e.done = d;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic mode, input logic [W-1:0] c, input logic b, input logic d);
    sched(1'b0, 1'b0, '0, 1'b0, 1'b0, mode, c, b, d);
  endtask

  task automatic apply(input stim_t s);
    reset         = s.rst;
    i_load        = s.load;
    i_load_val    = s.val;
    i_start       = s.start;
    i_stop        = s.stop;
    i_reload_mode = s.mode;
  endtask

  task automatic test_reset();
    int zeros;
    logic [W-1:0] expa;
    apply('{1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_checks++;
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_checks++;
    if (o_cnt_always !== 7'd99) begin n_fail++; $display("FAIL reset_always: got %0d want 99", o_cnt_always); end
    reset = 1'b0;
    expa  = 7'd99;
    zeros = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      expa = (expa == 7'd0) ? 7'd99 : expa - 7'd1;
      if (o_cnt_always === 7'd0) zeros++;
      n_checks++;
      if (o_cnt_always !== expa) begin
        n_fail++;
        $display("FAIL freerun cyc%0d: got %0d want %0d", k, o_cnt_always, expa);
      end
    end
    n_checks++;
    if (o_cnt_always !== 7'd99) begin n_fail++; $display("FAIL freerun_period: got %0d want 99", o_cnt_always); end
    n_checks++;
    if (zeros != 1) begin n_fail++; $display("FAIL freerun_zero_count: got %0d want 1", zeros); end
  endtask

  task automatic test_oneshot();
    stim_t s;
    exp_t  e;
    int    cyc = 0;
    sched(1'b0, 1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 1'b0);
    idle(1'b0, 7'd4, 1'b1, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0);
    idle(1'b0, 7'd2, 1'b1, 1'b0);
    idle(1'b0, 7'd1, 1'b1, 1'b0);
    idle(1'b0, 7'd0, 1'b1, 1'b1);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL oneshot cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      cyc++;
    end
  endtask

  task automatic test_reload();
    stim_t s;
    exp_t  e;
    int    cyc = 0;
    sched(1'b0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b1, 7'd3, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 7'd3, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      idle(1'b1, 7'd2, 1'b1, 1'b0);
      idle(1'b1, 7'd1, 1'b1, 1'b0);
      idle(1'b1, 7'd0, 1'b1, 1'b1);
      idle(1'b1, 7'd3, 1'b1, 1'b0);
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL reload cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      cyc++;
    end
  endtask

  task automatic test_pause();
    stim_t s;
    exp_t  e;
    int    cyc = 0;
    sched(1'b0, 1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd10, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd10, 1'b1, 1'b0);
    for (int c = 9; c >= 6; c--) idle(1'b0, 7'(c), 1'b1, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 7'd6, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b0, 7'd6, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd6, 1'b1, 1'b0);
    for (int c = 5; c >= 1; c--) idle(1'b0, 7'(c), 1'b1, 1'b0);
    idle(1'b0, 7'd0, 1'b1, 1'b1);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL pause cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      cyc++;
    end
  endtask

  task automatic test_boundary();
    stim_t s;
    exp_t  e;
    int    cyc = 0;
    sched(1'b0, 1'b1, 7'd120, 1'b0, 1'b0, 1'b0, 7'd100, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd100, 1'b1, 1'b0);
    idle(1'b0, 7'd99, 1'b1, 1'b0);
    sched(1'b0, 1'b1, 7'd4, 1'b0, 1'b1, 1'b0, 7'd4, 1'b0, 1'b0);
    sched(1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL boundary cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    int    cyc = 0;
    sched(1'b0, 1'b1, 7'd2, 1'b0, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0);
      idle(1'b0, 7'd1, 1'b1, 1'b0);
      idle(1'b0, 7'd0, 1'b1, 1'b1);
      idle(1'b0, 7'd0, 1'b0, 1'b0);
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      cyc++;
    end
  endtask

  task automatic test_midrun_reset();
    stim_t        s;
    exp_t         e;
    int           cyc   = 0;
    logic [W-1:0] expa  = '0;
    logic         track = 1'b0;
    sched(1'b0, 1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd10, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd10, 1'b1, 1'b0);
    idle(1'b0, 7'd9, 1'b1, 1'b0);
    idle(1'b0, 7'd8, 1'b1, 1'b0);
    idle(1'b0, 7'd7, 1'b1, 1'b0);
    sched(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    sched(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    idle(1'b0, 7'd0, 1'b0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (o_cnt !== e.cnt || o_busy !== e.busy || o_done !== e.done) begin
        n_fail++;
        $display("FAIL midrun_reset cyc%0d: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 cyc, o_cnt, o_busy, o_done, e.cnt, e.busy, e.done);
      end
      if (s.rst) begin
        expa  = 7'd99;
        track = 1'b1;
      end else if (track) begin
        expa = (expa == 7'd0) ? 7'd99 : expa - 7'd1;
      end
      if (track) begin
        n_checks++;
        if (o_cnt_always !== expa) begin
          n_fail++;
          $display("FAIL midrun_always cyc%0d: got %0d want %0d", cyc, o_cnt_always, expa);
        end
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_boundary();
    test_back_to_back();
    test_midrun_reset();
    apply('{1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
